// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole scheduler: state codes, hole count, LFSR seed and taps.
package mole_pkg;

    localparam int unsigned NUM_HOLES = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1, taken from a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSpawn = 3'd1;
    localparam logic [2:0] StUp    = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [1:0] hole);
        return NUM_HOLES'(1) << hole;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next hole; never reaches the all-zero state.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[6:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: raises one hole at a time, judges hits and timeouts, counts rounds.
// Optional build macro MOLE_NO_REPEAT_EN prevents the same hole being raised twice in a row.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int unsigned UP_TICKS  = 8,
    parameter int unsigned GAP_TICKS = 3,
    parameter int unsigned ROUNDS    = 16,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [3:0]         btn,
    output logic [3:0]         mole,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               busy,
    output logic               game_over
);

    localparam int unsigned UpW  = (UP_TICKS > 1) ? $clog2(UP_TICKS) : 1;
    localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    logic [2:0]         state_q, state_d;
    logic [3:0]         mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic [UpW-1:0]     up_cnt_q, up_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]         round_q, round_d;
    logic [7:0]         lfsr;
    logic [1:0]         hole;
    logic               hit;
    logic               unused_lfsr;

    mole_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Only the low two bits select a hole; the rest just feed the sequence.
    assign unused_lfsr = ^lfsr[7:2];

`ifdef MOLE_NO_REPEAT_EN
    logic [1:0] prev_hole_q, prev_hole_d;

    assign hole = (lfsr[1:0] == prev_hole_q) ? lfsr[1:0] + 2'd1 : lfsr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hole_q <= 2'd0;
        end else begin
            prev_hole_q <= prev_hole_d;
        end
    end

    always_comb begin
        prev_hole_d = prev_hole_q;
        if ((state_q == StIdle || state_q == StDone) && start) begin
            prev_hole_d = 2'd0;
        end else if (state_q == StSpawn) begin
            prev_hole_d = hole;
        end
    end
`else
    assign hole = lfsr[1:0];
`endif

    // Exact pattern match only; extra bits alongside the right one do not count.
    assign hit = (state_q == StUp) && (btn == mole_q);

    always_comb begin
        state_d   = state_q;
        mole_d    = mole_q;
        score_d   = score_q;
        misses_d  = misses_q;
        up_cnt_d  = up_cnt_q;
        gap_cnt_d = gap_cnt_q;
        round_d   = round_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    score_d  = '0;
                    misses_d = '0;
                    round_d  = '0;
                    state_d  = StSpawn;
                end
            end
            StSpawn: begin
                mole_d   = hole_onehot(hole);
                up_cnt_d = '0;
                state_d  = StUp;
            end
            StUp: begin
                if (hit || (tick && up_cnt_q == UpW'(UP_TICKS - 1))) begin
                    if (hit) begin
                        score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    end else begin
                        misses_d = (misses_q == '1) ? misses_q : misses_q + SCORE_W'(1);
                    end
                    mole_d    = '0;
                    gap_cnt_d = '0;
                    round_d   = round_q + 8'd1;
                    state_d   = StGap;
                end else if (tick) begin
                    up_cnt_d = up_cnt_q + UpW'(1);
                end
            end
            StGap: begin
                if (tick) begin
                    if (gap_cnt_q == GapW'(GAP_TICKS - 1)) begin
                        state_d = (round_q == 8'(ROUNDS)) ? StDone : StSpawn;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                mole_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mole_q    <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            up_cnt_q  <= '0;
            gap_cnt_q <= '0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            mole_q    <= mole_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            up_cnt_q  <= up_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            round_q   <= round_d;
        end
    end

    assign mole      = mole_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign busy      = (state_q == StSpawn) || (state_q == StUp) || (state_q == StGap);
    assign game_over = (state_q == StDone);

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed and randomized games against a round-level model.
module tb_mole_scheduler;

    localparam int UP  = 4;
    localparam int GAP = 2;
    localparam int RN  = 3;
    localparam int SW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    btn = 4'b0;
    logic [3:0]    mole;
    logic [SW-1:0] score;
    logic [SW-1:0] misses;
    logic          busy;
    logic          game_over;

    mole_scheduler #(
        .UP_TICKS  (UP),
        .GAP_TICKS (GAP),
        .ROUNDS    (RN),
        .SCORE_W   (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .btn       (btn),
        .mole      (mole),
        .score     (score),
        .misses    (misses),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Clocks elapsed since the last reset edge; the LFSR value follows from this alone.
    int ncyc;
    always @(posedge clk) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    int checks = 0;
    int errors = 0;
    int exp_score, exp_miss, rounds, period, tph, prev_hole;

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        logic       fb;
        v = 8'hA5;
        for (int i = 0; i < n; i++) begin
            fb = v[7] ^ v[5] ^ v[4] ^ v[3];
            v  = {v[6:0], fb};
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit t, input logic [3:0] b, input bit s);
        tick  = t;
        btn   = b;
        start = s;
        @(posedge clk);
        #1;
    endtask

    task automatic pace(output bit t);
        t = ((tph % period) == period - 1);
        tph++;
    endtask

    task automatic noise_btn(input int hole, output logic [3:0] b);
        int other;
        other = (hole + 1 + int'($urandom_range(0, 2))) % 4;
        case ($urandom_range(0, 3))
            0: b = 4'b0001 << other;
            1: b = 4'b1111;
            2: b = (4'b0001 << hole) | (4'b0001 << other);
            default: b = 4'b0000;
        endcase
    endtask

    task automatic spawn_hole(output int hole);
        hole = int'(lfsr_at(ncyc) & 8'h03);
`ifdef MOLE_NO_REPEAT_EN
        if (hole == prev_hole) hole = (hole + 1) % 4;
        checks++;
        assert (hole != prev_hole) else begin
            errors++;
            $error("FAIL no_repeat: observed %0d expected not %0d", hole, prev_hole);
        end
`endif
        prev_hole = hole;
    endtask

    // Entered with the DUT in SPAWN; returns with it in SPAWN again or in DONE.
    task automatic play_round(input int mode, input bit noise, output bit last);
        int         hole, k, j, idx, press;
        bit         t;
        logic [3:0] oh, b;
        spawn_hole(hole);
        oh    = 4'b0001 << hole;
        press = (mode == -2) ? int'($urandom_range(0, UP * period + 1)) - 1 : mode;
        check("spawn_mole", mole, 0);
        check("spawn_busy", busy, 1);
        pace(t);
        step(t, 4'b0, 1'b0);
        check("up_mole", mole, oh);
        k   = 0;
        idx = 0;
        while (idx < 200) begin
            pace(t);
            if (idx == press) b = oh;
            else if (noise) noise_btn(hole, b);
            else b = 4'b0;
            step(t, b, noise ? 1'($urandom_range(0, 1)) : 1'b0);
            idx++;
            if (b == oh) begin
                exp_score = (exp_score == 255) ? 255 : exp_score + 1;
                break;
            end
            if (t) begin
                k++;
                if (k == UP) begin
                    exp_miss = (exp_miss == 255) ? 255 : exp_miss + 1;
                    if (period == 1) check("up_len", idx, UP);
                    break;
                end
            end
            check("up_hold", mole, oh);
            check("up_score", score, exp_score);
        end
        check("gap_mole", mole, 0);
        check("score", score, exp_score);
        check("misses", misses, exp_miss);
        check("gap_busy", busy, 1);
        rounds++;
        j = 0;
        while (j < GAP) begin
            pace(t);
            if (noise) noise_btn(hole, b);
            else b = 4'b0;
            step(t, b, 1'b0);
            if (t) j++;
            if (j < GAP) begin
                check("gap_dark", mole, 0);
                check("gap_score", score, exp_score);
            end
        end
        last = (rounds == RN);
        check("end_game_over", game_over, last);
        check("end_busy", busy, !last);
        check("end_mole", mole, 0);
    endtask

    task automatic begin_game(input int per);
        period    = per;
        tph       = 0;
        exp_score = 0;
        exp_miss  = 0;
        rounds    = 0;
        prev_hole = 0;
        step(1'b0, 4'b0, 1'b1);
        check("start_busy", busy, 1);
        check("start_score_clr", score, 0);
        check("start_miss_clr", misses, 0);
        check("start_game_over", game_over, 0);
    endtask

    task automatic play_game(input int mode, input bit noise, input int per);
        bit last;
        begin_game(per);
        last = 1'b0;
        while (!last) play_round(mode, noise, last);
        check("final_score", score, exp_score);
        check("final_miss", misses, exp_miss);
    endtask

    initial begin
        bit last;
        // Reset held with start high: everything stays quiet.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_mole", mole, 0);
        check("rst_score", score, 0);
        check("rst_miss", misses, 0);
        check("rst_busy", busy, 0);
        check("rst_game_over", game_over, 0);
        rst = 1'b0;

        play_game(0, 1'b0, 1);          // every mole hit on its first UP clock
        check("hits_total", score, RN);
        check("hits_miss", misses, 0);
        play_game(-1, 1'b0, 1);         // no presses: all timeouts, restart from DONE
        check("timeouts_total", misses, RN);
        check("timeouts_score", score, 0);
        play_game(2, 1'b1, 1);          // wrong and multi-bit presses before the exact one
        play_game(UP - 1, 1'b0, 1);     // exact press on the same clock as the last tick
        check("collide_score", score, RN);
        check("collide_miss", misses, 0);
        play_game(-1, 1'b0, 3);         // slow pacing, all timeouts
        for (int g = 0; g < 8; g++) begin
            play_game(-2, 1'b1, int'($urandom_range(1, 3)));
        end

        // Abort while a mole is up after scoring one hit.
        begin_game(1);
        play_round(0, 1'b0, last);
        step(1'b0, 4'b0, 1'b0);
        check("midup_mole", mole != 4'b0, 1);
        rst = 1'b1;
        step(1'b1, 4'b0, 1'b0);
        check("midrst_mole", mole, 0);
        check("midrst_score", score, 0);
        check("midrst_busy", busy, 0);
        check("midrst_game_over", game_over, 0);
        rst = 1'b0;
        step(1'b1, 4'b0, 1'b0);
        check("idle_stays", busy, 0);
        play_game(-2, 1'b1, 1);
        play_game(-2, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
